// File: rtl/f_truth_scanner_if.sv
// Scan bus between the self-test logic, the 4-input function unit and the truth-table scanner.
// The slave modport is the scanner: it takes start/abort/f_in and drives vectors and results.
interface f_truth_scanner_if;
  logic        start;
  logic        abort;
  logic        f_in;
  logic        vec_a;
  logic        vec_b;
  logic        vec_c;
  logic        vec_d;
  logic        busy;
  logic        done;
  logic [15:0] truth;
  logic [4:0]  ones;
  logic        pass;

  modport master (
    output start, abort, f_in,
    input  vec_a, vec_b, vec_c, vec_d, busy, done, truth, ones, pass
  );

  modport slave (
    input  start, abort, f_in,
    output vec_a, vec_b, vec_c, vec_d, busy, done, truth, ones, pass
  );
endinterface

// File: rtl/f_truth_scanner.sv
// Steps {A,B,C,D} through 0..15, holding each SETTLE+1 cycles, then publishes truth/ones/pass.
// Latency 16*(SETTLE+1) cycles from accepted start to the one-cycle done pulse; start is ignored unless idle.
module f_truth_scanner #(
  parameter int          SETTLE   = 0,
  parameter logic [15:0] EXPECTED = 16'h0DD0
) (
  input  logic              clk,
  input  logic              rst,
  f_truth_scanner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(SETTLE);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hc_q, hc_d;
  logic [15:0] shadow_q, shadow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] truth_q, truth_d;
  logic [4:0]  ones_q, ones_d;
  logic        pass_q, pass_d;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hc_d     = hc_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    truth_d  = truth_q;
    ones_d   = ones_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SCAN;
          idx_d    = 4'd0;
          hc_d     = 8'd0;
          shadow_d = 16'h0000;
          busy_d   = 1'b1;
        end
      end
      SCAN: begin
        // abort wins over a sample landing on the same edge, even the last one
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          hc_d    = 8'd0;
          busy_d  = 1'b0;
        end else if (hc_q == HOLD_LAST) begin
          shadow_d[idx_q] = bus.f_in;
          hc_d            = 8'd0;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            idx_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            truth_d = shadow_d;
            ones_d  = popcount16(shadow_d);
            pass_d  = (shadow_d == EXPECTED);
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          hc_d = hc_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      hc_q     <= 8'd0;
      shadow_q <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      truth_q  <= 16'h0000;
      ones_q   <= 5'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hc_q     <= hc_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      truth_q  <= truth_d;
      ones_q   <= ones_d;
      pass_q   <= pass_d;
    end
  end

  // idx is held at zero outside SCAN, so it doubles as the vector register
  assign bus.vec_a = idx_q[3];
  assign bus.vec_b = idx_q[2];
  assign bus.vec_c = idx_q[1];
  assign bus.vec_d = idx_q[0];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.truth = truth_q;
  assign bus.ones  = ones_q;
  assign bus.pass  = pass_q;

endmodule

// File: tb/tb_f_truth_scanner.sv
// Bench for f_truth_scanner: table of function-unit models plus hand sequences for abort, reset and start pokes.
// Two instances (SETTLE 0 and 3) share one clock; a done-pulse scoreboard checks results and timing.
module tb_f_truth_scanner;

  localparam int NORMAL = 0, POKE = 1, ABORT = 2, RESET = 3, START_ABORT = 4;

  typedef struct {
    int          fm;
    logic [15:0] truth;
    logic [4:0]  ones;
    logic        pass;
  } vec_t;

  typedef struct {
    logic [15:0] truth;
    logic [4:0]  ones;
    logic        pass;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst0, rst3;
  int   cyc;
  int   checks;
  int   errors;
  int   fmode0;
  exp_t q0[$];
  exp_t q3[$];
  logic [15:0] pub_truth [2];
  logic [4:0]  pub_ones  [2];
  logic        pub_pass  [2];
  vec_t        tbl [6];

  f_truth_scanner_if b0 ();
  f_truth_scanner_if b3 ();

  f_truth_scanner #(.SETTLE(0), .EXPECTED(16'h0DD0)) dut0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  f_truth_scanner #(.SETTLE(3), .EXPECTED(16'h0DD0)) dut3 (.clk(clk), .rst(rst3), .bus(b3.slave));

  // mode 0 correct unit, 1 stuck-at-1, 2 stuck-at-0, 3 inverted output
  function automatic logic fmod(input logic [3:0] v, input int m);
    logic g;
    g = (v[3] ^ v[2]) & (v[1] | ~v[0]);
    case (m)
      1: return 1'b1;
      2: return 1'b0;
      3: return ~g;
      default: return g;
    endcase
  endfunction

  assign b0.f_in = fmod({b0.vec_a, b0.vec_b, b0.vec_c, b0.vec_d}, fmode0);
  assign b3.f_in = fmod({b3.vec_a, b3.vec_b, b3.vec_c, b3.vec_d}, 0);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] vec_of(input int s);
    if (s == 0) return 32'({b0.vec_a, b0.vec_b, b0.vec_c, b0.vec_d});
    return 32'({b3.vec_a, b3.vec_b, b3.vec_c, b3.vec_d});
  endfunction
  function automatic logic [31:0] busy_of(input int s);
    return (s == 0) ? 32'(b0.busy) : 32'(b3.busy);
  endfunction
  function automatic logic [31:0] done_of(input int s);
    return (s == 0) ? 32'(b0.done) : 32'(b3.done);
  endfunction
  function automatic logic [31:0] truth_of(input int s);
    return (s == 0) ? 32'(b0.truth) : 32'(b3.truth);
  endfunction
  function automatic logic [31:0] ones_of(input int s);
    return (s == 0) ? 32'(b0.ones) : 32'(b3.ones);
  endfunction
  function automatic logic [31:0] pass_of(input int s);
    return (s == 0) ? 32'(b0.pass) : 32'(b3.pass);
  endfunction

  task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", s, nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_vec",   s, vec_of(s),   32'd0);
    chk("rst_busy",  s, busy_of(s),  32'd0);
    chk("rst_done",  s, done_of(s),  32'd0);
    chk("rst_truth", s, truth_of(s), 32'd0);
    chk("rst_ones",  s, ones_of(s),  32'd0);
    chk("rst_pass",  s, pass_of(s),  32'd0);
  endtask

  task automatic chk_held(input string nm, input int s);
    chk({nm, "_truth"}, s, truth_of(s), 32'(pub_truth[s]));
    chk({nm, "_ones"},  s, ones_of(s),  32'(pub_ones[s]));
    chk({nm, "_pass"},  s, pass_of(s),  32'(pub_pass[s]));
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) b0.start = v;
    else        b3.start = v;
  endtask

  task automatic mon_done(input int s);
    exp_t e;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q3.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d done_unexpected: got done=1 expected no pulse (cycle %0d)", s, cyc);
    end else begin
      if (s == 0) e = q0.pop_front();
      else        e = q3.pop_front();
      chk("done_cycle", s, 32'(cyc), 32'(e.cyc));
      chk("truth",      s, truth_of(s), 32'(e.truth));
      chk("ones",       s, ones_of(s),  32'(e.ones));
      chk("pass",       s, pass_of(s),  32'(e.pass));
      pub_truth[s] = e.truth;
      pub_ones[s]  = e.ones;
      pub_pass[s]  = e.pass;
    end
  endtask

  always @(negedge clk) begin
    if (b0.done) mon_done(0);
    if (b3.done) mon_done(1);
  end

  // Called just after a negedge; start is sampled at the following posedge (E0).
  task automatic run_scan(input int s, input int mode, input int k,
                          input logic [15:0] et, input logic [4:0] eo, input logic ep);
    int   settle;
    int   e0;
    exp_t e;
    settle = (s == 0) ? 0 : 3;
    set_start(s, 1'b1);
    if (mode == START_ABORT) b0.abort = 1'b1;
    @(negedge clk);
    set_start(s, 1'b0);
    b0.abort = 1'b0;
    e0 = cyc;
    if (mode == NORMAL || mode == POKE || mode == START_ABORT) begin
      e.truth = et;
      e.ones  = eo;
      e.pass  = ep;
      e.cyc   = e0 + 16 * (settle + 1);
      if (s == 0) q0.push_back(e);
      else        q3.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      for (int h = 0; h <= settle; h++) begin
        if (i != 0 || h != 0) @(negedge clk);
        set_start(s, 1'b0);
        chk("scan_vec",   s, vec_of(s),  32'(i));
        chk("scan_busy",  s, busy_of(s), 32'd1);
        chk("scan_done",  s, done_of(s), 32'd0);
        chk("scan_truth", s, truth_of(s), 32'(pub_truth[s]));
        if (mode == POKE && i == 5 && h == 0) set_start(s, 1'b1);
        if (mode == ABORT && i == k && h == 0) begin
          b0.abort = 1'b1;
          @(negedge clk);
          b0.abort = 1'b0;
          chk("abort_busy", 0, busy_of(0), 32'd0);
          chk("abort_vec",  0, vec_of(0),  32'd0);
          chk("abort_done", 0, done_of(0), 32'd0);
          chk_held("abort", 0);
          return;
        end
        if (mode == RESET && i == k && h == 0) begin
          rst0 = 1'b1;
          @(negedge clk);
          rst0 = 1'b0;
          chk_reset(0);
          pub_truth[0] = 16'h0000;
          pub_ones[0]  = 5'd0;
          pub_pass[0]  = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    chk("done_pulse", s, done_of(s), 32'd1);
    chk("done_busy",  s, busy_of(s), 32'd0);
    chk("done_vec",   s, vec_of(s),  32'd0);
    if (mode == POKE) set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    chk("idle_busy", s, busy_of(s), 32'd0);
    chk("idle_done", s, done_of(s), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fmode0 = 0;
    rst0 = 1'b1;
    rst3 = 1'b1;
    b0.start = 1'b0;
    b0.abort = 1'b0;
    b3.start = 1'b0;
    b3.abort = 1'b0;
    for (int s = 0; s < 2; s++) begin
      pub_truth[s] = 16'h0000;
      pub_ones[s]  = 5'd0;
      pub_pass[s]  = 1'b0;
    end
    tbl[0] = '{0, 16'h0DD0, 5'd6,  1'b1};
    tbl[1] = '{1, 16'hFFFF, 5'd16, 1'b0};
    tbl[2] = '{0, 16'h0DD0, 5'd6,  1'b1};
    tbl[3] = '{2, 16'h0000, 5'd0,  1'b0};
    tbl[4] = '{3, 16'hF22F, 5'd10, 1'b0};
    tbl[5] = '{0, 16'h0DD0, 5'd6,  1'b1};

    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk_reset(0);

    for (int i = 0; i < 6; i++) begin
      fmode0 = tbl[i].fm;
      run_scan(0, NORMAL, 0, tbl[i].truth, tbl[i].ones, tbl[i].pass);
    end

    run_scan(1, NORMAL, 0, 16'h0DD0, 5'd6, 1'b1);

    // pokes mid-scan and in the DONE cycle, then a back-to-back start in the one idle cycle
    run_scan(0, POKE, 0, 16'h0DD0, 5'd6, 1'b1);
    run_scan(0, NORMAL, 0, 16'h0DD0, 5'd6, 1'b1);
    run_scan(0, START_ABORT, 0, 16'h0DD0, 5'd6, 1'b1);

    run_scan(0, ABORT, 7, 16'h0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk_held("post_abort", 0);
    run_scan(0, ABORT, 15, 16'h0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_abort15_busy", 0, busy_of(0), 32'd0);

    run_scan(0, RESET, 10, 16'h0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset(0);
    run_scan(0, NORMAL, 0, 16'h0DD0, 5'd6, 1'b1);

    repeat (20) @(negedge clk);
    chk("pending_done", 0, 32'(q0.size()), 32'd0);
    chk("pending_done", 1, 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
